// File: rtl/seq_divider_16.sv
//==============================================================================
// Module      : seq_divider_16
// Description : Multi-cycle unsigned restoring divider. One shift/subtract
//               step per clock under a start/done handshake; busy is high
//               while an operation is in flight.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_divider_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;          // shifting dividend / quotient
    logic [WIDTH-1:0] r_q, r_d;          // partial remainder
    logic [WIDTH-1:0] d_q, d_d;          // latched divisor
    logic             zero_q, zero_d;    // latched divisor was zero
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dz_q, dz_d;

    // One restoring step: shift in the next dividend bit, then trial-subtract
    // at WIDTH+1 bits. The borrow bit of the difference doubles as the
    // "partial remainder >= divisor" decision.
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;

    // Combinational datapath for one iteration.
    always_comb begin
        w_shifted = {r_q, q_q[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, d_q};
        w_ge      = ~w_diff[WIDTH];
        w_r_next  = w_ge ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
        w_q_next  = {q_q[WIDTH-2:0], w_ge};
    end

    // Next-state and datapath control for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dz_d        = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    count_d = '0;
                    zero_d  = (divisor == '0);
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (zero_q) begin
                    // Zero divisor: no iterations; q_q still holds the
                    // untouched dividend, which becomes the remainder.
                    quotient_d  = '1;
                    remainder_d = q_q;
                    dz_d        = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    q_d     = w_q_next;
                    r_d     = w_r_next;
                    count_d = count_q + CW'(1);
                    if (count_q == C_LAST_STEP) begin
                        // Results register on the same edge that raises done.
                        quotient_d  = w_q_next;
                        remainder_d = w_r_next;
                        dz_d        = 1'b0;
                        state_d     = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dz_q        <= dz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;

endmodule

`default_nettype wire
